// File: rtl/mfp_ahb_uart_tx_pkg.sv
// Register map, STATUS bit layout and reset defaults shared by the AHB-Lite UART transmitter.
// The default divisor can be overridden by predefining MFP_UART_BAUDDIV_DEFAULT.
`ifndef MFP_UART_BAUDDIV_DEFAULT
`define MFP_UART_BAUDDIV_DEFAULT 16'd434
`endif

package mfp_ahb_uart_tx_pkg;

  typedef enum logic [1:0] {
    REG_TXDATA  = 2'd0,
    REG_STATUS  = 2'd1,
    REG_BAUDDIV = 2'd2,
    REG_RSVD    = 2'd3
  } reg_idx_e;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_PARITY    = 4;
  localparam int ST_COUNT_LSB = 8;

  localparam logic [15:0] BAUDDIV_DEFAULT = `MFP_UART_BAUDDIV_DEFAULT;

  // Down-counter reload for one bit time; a divisor of 0 is treated as 1.
  function automatic logic [15:0] bit_reload(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

endpackage

// File: rtl/mfp_ahb_uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter: registered read port, wrapping pointers,
// and a push into a full FIFO is still accepted when a pop happens in the same cycle.
module mfp_uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               HCLK,
  input  logic               SI_Reset,
  input  logic               push,
  input  logic               pop,
  input  logic [7:0]         wr_data,
  output logic [7:0]         rd_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count
);

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
    end
  end

  // Storage and read port carry data only; a simultaneous push to the popped slot reads the old byte.
  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
    if (do_pop)  rd_data     <= mem[rd_ptr];
  end

endmodule

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite slave UART transmitter: TX FIFO plus 8N1 serialiser on UART_TX.
// Defining MFP_UART_TX_PARITY_EN adds an even parity bit (8E1) and sets STATUS[4].
module mfp_ahb_uart_tx
  import mfp_ahb_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter int          FIFO_AW     = 4,
  parameter logic [15:0] BAUDDIV_RST = BAUDDIV_DEFAULT
) (
  input  logic        HCLK,
  input  logic        SI_Reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        UART_TX
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

`ifdef MFP_UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  state_e             state, state_nx;
  logic [15:0]        bit_cnt, bit_cnt_nx;
  logic [2:0]         bit_idx, bit_idx_nx;
  logic [15:0]        bauddiv;
  logic               overflow;
  logic               tx_nx;
  logic               bit_end;
  logic               ap_valid, ap_write, ap_accept;
  logic [1:0]         ap_addr;
  logic               wr_txdata, wr_status, wr_bauddiv;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [7:0]         tx_byte;
  logic [FIFO_AW:0]   fifo_count;
  logic [31:0]        status_word;
  logic               unused_bits;

  assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};
  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;

  // Address phase capture
  assign ap_accept = HSEL && HTRANS[1] && HREADY;

  always_ff @(posedge HCLK) begin
    if (SI_Reset) ap_valid <= 1'b0;
    else          ap_valid <= ap_accept;
  end

  always_ff @(posedge HCLK) begin
    if (ap_accept) begin
      ap_addr  <= HADDR[3:2];
      ap_write <= HWRITE;
    end
  end

  // Data phase register writes
  assign wr_txdata  = ap_valid && ap_write && (reg_idx_e'(ap_addr) == REG_TXDATA);
  assign wr_status  = ap_valid && ap_write && (reg_idx_e'(ap_addr) == REG_STATUS);
  assign wr_bauddiv = ap_valid && ap_write && (reg_idx_e'(ap_addr) == REG_BAUDDIV);

  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      bauddiv  <= BAUDDIV_RST;
      overflow <= 1'b0;
    end else begin
      if (wr_bauddiv) bauddiv <= HWDATA[15:0];
      if (wr_txdata && fifo_full && !fifo_pop) overflow <= 1'b1;
      else if (wr_status && HWDATA[ST_OVF])    overflow <= 1'b0;
    end
  end

  mfp_uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .HCLK     (HCLK),
    .SI_Reset (SI_Reset),
    .push     (wr_txdata),
    .pop      (fifo_pop),
    .wr_data  (HWDATA[7:0]),
    .rd_data  (tx_byte),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Serialiser state; the FIFO read register holds the byte for the whole frame
  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      UART_TX <= 1'b1;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      bit_idx <= bit_idx_nx;
      UART_TX <= tx_nx;
    end
  end

  assign bit_end = (bit_cnt == 16'd0);

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    bit_idx_nx = bit_idx;
    fifo_pop   = 1'b0;
    if (state == S_IDLE) begin
      if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        state_nx   = S_START;
        bit_cnt_nx = bit_reload(bauddiv);
      end
    end else if (!bit_end) begin
      bit_cnt_nx = bit_cnt - 16'd1;
    end else begin
      // Bit boundary: the divisor is re-sampled here so a mid-frame write affects later bits only
      bit_cnt_nx = bit_reload(bauddiv);
      case (state)
        S_START: begin
          state_nx   = S_DATA;
          bit_idx_nx = 3'd0;
        end
        S_DATA: begin
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
            state_nx = S_PARITY;
`else
            state_nx = S_STOP;
`endif
          end
        end
        S_PARITY: state_nx = S_STOP;
        default: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_nx = S_START;
          end else begin
            state_nx = S_IDLE;
          end
        end
      endcase
    end
  end

  // Line level registered from the next state so UART_TX is glitch-free
  always_comb begin
    case (state_nx)
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = tx_byte[bit_idx_nx];
      S_PARITY: tx_nx = ^tx_byte;
      default:  tx_nx = 1'b1;
    endcase
  end

  always_comb begin
    status_word                        = '0;
    status_word[ST_BUSY]               = (state != S_IDLE);
    status_word[ST_FULL]               = fifo_full;
    status_word[ST_EMPTY]              = fifo_empty;
    status_word[ST_OVF]                = overflow;
    status_word[ST_PARITY]             = PARITY_EN;
    status_word[ST_COUNT_LSB +: 8]     = 8'(fifo_count);
  end

  always_comb begin
    HRDATA = '0;
    if (ap_valid) begin
      case (reg_idx_e'(ap_addr))
        REG_STATUS:  HRDATA = status_word;
        REG_BAUDDIV: HRDATA = {16'd0, bauddiv};
        default:     HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Bench for mfp_ahb_uart_tx: frame-level reference model compared every cycle, directed
// waveform/status literals, then randomized pipelined AHB traffic.
module tb_mfp_ahb_uart_tx;

`ifdef MFP_UART_TX_PARITY_EN
  localparam int          NBITS = 11;
  localparam logic [31:0] PBIT  = 32'h10;
  localparam logic [21:0] PAT1  = 22'(11'b10010101010);
  localparam logic [21:0] PAT2  = {11'b10000011110, 11'b10101000110};
  localparam logic [21:0] PAT5  = 22'(10'b1000111100);
  localparam logic [21:0] PAT6  = 22'(11'b11000001110);
`else
  localparam int          NBITS = 10;
  localparam logic [31:0] PBIT  = 32'h0;
  localparam logic [21:0] PAT1  = 22'(10'b1010101010);
  localparam logic [21:0] PAT2  = 22'({10'b1000011110, 10'b1101000110});
  localparam logic [21:0] PAT5  = 22'(9'b100111100);
  localparam logic [21:0] PAT6  = 22'(10'b1000001110);
`endif

  logic        HCLK, SI_Reset, HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP, UART_TX;

  int n_checks = 0;
  int n_errors = 0;

  mfp_ahb_uart_tx dut (
    .HCLK(HCLK), .SI_Reset(SI_Reset), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .UART_TX(UART_TX)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, current frame as an array of line levels
  logic [7:0]  q[$];
  bit          m_bits[11];
  int          m_pos, m_rem, m_baud;
  bit          m_active, m_ovf, m_init;
  bit          m_dp_valid, m_dp_write;
  logic [1:0]  m_dp_addr;

  function automatic int eff_div(input int b);
    return (b == 0) ? 1 : b;
  endfunction

  task automatic start_frame();
    logic [7:0] b;
    b = q.pop_front();
    m_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
    m_bits[9] = ^b;
    m_bits[NBITS-1] = 1'b1;
    m_pos = 0;
    m_rem = eff_div(m_baud);
    m_active = 1'b1;
  endtask

  always @(posedge HCLK) begin
    if (SI_Reset) begin
      q.delete();
      m_active = 1'b0; m_pos = 0; m_rem = 0; m_baud = 434; m_ovf = 1'b0;
      m_dp_valid = 1'b0; m_dp_write = 1'b0; m_dp_addr = 2'd0; m_init = 1'b1;
    end else if (m_init) begin
      if (!m_active) begin
        if (q.size() > 0) start_frame();
      end else if (m_rem > 1) begin
        m_rem--;
      end else if (m_pos < NBITS-1) begin
        m_pos++;
        m_rem = eff_div(m_baud);
      end else if (q.size() > 0) begin
        start_frame();
      end else begin
        m_active = 1'b0;
      end
      if (m_dp_valid && m_dp_write) begin
        case (m_dp_addr)
          2'd0: if (q.size() < 16) q.push_back(HWDATA[7:0]); else m_ovf = 1'b1;
          2'd1: if (HWDATA[3]) m_ovf = 1'b0;
          2'd2: m_baud = int'(HWDATA[15:0]);
          default: ;
        endcase
      end
      m_dp_valid = HSEL && HTRANS[1] && HREADY;
      m_dp_addr  = HADDR[3:2];
      m_dp_write = HWRITE;
    end
  end

  function automatic logic [31:0] model_rdata();
    int r;
    r = 0;
    if (m_dp_valid) begin
      case (m_dp_addr)
        2'd1: r = (m_active ? 1 : 0) + ((q.size() == 16) ? 2 : 0) + ((q.size() == 0) ? 4 : 0)
                + (m_ovf ? 8 : 0) + int'(PBIT) + (q.size() << 8);
        2'd2: r = m_baud;
        default: r = 0;
      endcase
    end
    return 32'(r);
  endfunction

  always @(negedge HCLK) begin
    if (m_init && !SI_Reset) begin
      check("uart_tx", 32'(UART_TX), m_active ? 32'(m_bits[m_pos]) : 32'd1);
      check("hrdata", HRDATA, model_rdata());
      check("hready_resp", {30'd0, HREADYOUT, HRESP}, 32'h2);
    end
  end

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0;
  endtask

  task automatic ahb_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = {28'd0, a, 2'b00}; HWRITE = 1'b1; HREADY = 1'b1;
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = d;
  endtask

  task automatic ahb_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = {28'd0, a, 2'b00}; HWRITE = 1'b0; HREADY = 1'b1;
    @(posedge HCLK); #1;
    bus_idle();
    @(negedge HCLK);
    d = HRDATA;
  endtask

  task automatic check_wave(input string name, input logic [21:0] pat, input int nbits,
                            input int div, input int skip);
    repeat (skip) @(negedge HCLK);
    for (int k = 0; k < nbits * div; k++) begin
      @(negedge HCLK);
      check(name, 32'(UART_TX), 32'(pat[k / div]));
    end
  endtask

  logic [31:0] rd;
  logic        prev_baud_wr;

  initial begin
    SI_Reset = 1'b1; HREADY = 1'b1; HWDATA = 32'd0; HSIZE = 3'b010;
    bus_idle();
    repeat (3) @(posedge HCLK);
    #1 SI_Reset = 1'b0;
    @(negedge HCLK);
    check("reset_tx", 32'(UART_TX), 32'd1);
    check("reset_hrdata", HRDATA, 32'd0);
    ahb_read(2'd1, rd);  check("reset_status", rd, 32'h4 | PBIT);
    ahb_read(2'd2, rd);  check("reset_bauddiv", rd, 32'd434);

    // Single byte 0x55 at divisor 4
    ahb_write(2'd2, 32'd4);
    ahb_write(2'd0, 32'h55);
    check_wave("frame_55", PAT1, NBITS, 4, 2);
    ahb_read(2'd1, rd);  check("idle_after_55", rd, 32'h4 | PBIT);

    // Back-to-back 0xA3, 0x0F in consecutive transfers at divisor 2
    ahb_write(2'd2, 32'd2);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HWDATA = 32'hA3;
    @(posedge HCLK); #1;
    bus_idle(); HWDATA = 32'h0F;
    check_wave("frames_a3_0f", PAT2, 2 * NBITS, 2, 1);

    // Divisor change 8 -> 2 during the start bit of 0x3C
    ahb_write(2'd2, 32'd8);
    ahb_write(2'd0, 32'h3C);
    ahb_write(2'd2, 32'd2);
    check_wave("start_div8", 22'd0, 1, 8, 0);
    check_wave("data_div2", PAT5, NBITS - 1, 2, 0);

    // Divisor 0 acts as 1; 0x07 has odd weight
    ahb_write(2'd2, 32'd0);
    ahb_write(2'd0, 32'h07);
    check_wave("frame_07_div0", PAT6, NBITS, 1, 2);

    // Reset during data bit 3 of 0x55
    ahb_write(2'd2, 32'd4);
    ahb_write(2'd0, 32'h55);
    repeat (18) @(posedge HCLK);
    #1;
    @(negedge HCLK);
    check("mid_frame_bit3", 32'(UART_TX), 32'd0);
    @(posedge HCLK); #1 SI_Reset = 1'b1;
    @(posedge HCLK); #1 SI_Reset = 1'b0;
    @(negedge HCLK);
    check("abort_tx", 32'(UART_TX), 32'd1);
    ahb_read(2'd1, rd);  check("abort_status", rd, 32'h4 | PBIT);
    ahb_read(2'd2, rd);  check("abort_bauddiv", rd, 32'd434);

    // Overflow: 18 writes at divisor 1000
    ahb_write(2'd2, 32'd1000);
    for (int i = 0; i < 18; i++) ahb_write(2'd0, 32'(8'h30 + i));
    ahb_read(2'd1, rd);  check("ovf_status", rd, 32'h100B | PBIT);
    ahb_write(2'd1, 32'h8);
    ahb_read(2'd1, rd);  check("ovf_cleared", rd, 32'h1003 | PBIT);
    ahb_read(2'd3, rd);  check("reserved_read", rd, 32'd0);
    ahb_read(2'd0, rd);  check("txdata_read", rd, 32'd0);
    ahb_write(2'd2, 32'd0);
    repeat (1400) @(posedge HCLK);
    ahb_read(2'd1, rd);  check("drained_status", rd, 32'h4 | PBIT);

    // Randomized pipelined traffic with small divisors
    ahb_write(2'd2, 32'd3);
    prev_baud_wr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge HCLK); #1;
      HWDATA = prev_baud_wr ? 32'($urandom_range(0, 4)) : $urandom;
      HSEL   = ($urandom % 4) != 0;
      HTRANS = 2'($urandom);
      HADDR  = $urandom;
      HWRITE = 1'($urandom);
      HREADY = ($urandom % 8) != 0;
      prev_baud_wr = HSEL && HTRANS[1] && HREADY && HWRITE && (HADDR[3:2] == 2'd2);
    end
    @(posedge HCLK); #1;
    bus_idle(); HREADY = 1'b1;
    repeat (4) @(posedge HCLK);
    @(negedge HCLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
